deadtime_gate_driver: RTL and testbench

//  Three-phase dead-time inserter sitting directly downstream of the per-phase PWM stages.

---
 rtl/deadtime_gate_driver_if.sv | 36 +++
 rtl/deadtime_gate_driver.sv | 138 +++++++++++++
 tb/tb_deadtime_gate_driver.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/deadtime_gate_driver_if.sv
// Command/status bundle for the three-phase dead-time gate driver.
// master: PWM/control side driving commands; slave: the gate driver itself.
// DEADTIME_PROG_EN adds the runtime dead-time input dt_cfg (and the DT_W parameter sizing it).
interface deadtime_gate_driver_if
`ifdef DEADTIME_PROG_EN
    #(parameter int unsigned DT_W = 8)
`endif
    ;
    logic       enable;
    logic [2:0] pwm_cmd;
    logic       fault;
    logic       fault_clr;
`ifdef DEADTIME_PROG_EN
    logic [DT_W-1:0] dt_cfg;
`endif
    logic [2:0] gate_hi;
    logic [2:0] gate_lo;
    logic [2:0] dt_active;
    logic       fault_latched;

    modport master (
`ifdef DEADTIME_PROG_EN
        output dt_cfg,
`endif
        output enable, pwm_cmd, fault, fault_clr,
        input  gate_hi, gate_lo, dt_active, fault_latched
    );

    modport slave (
`ifdef DEADTIME_PROG_EN
        input  dt_cfg,
`endif
        input  enable, pwm_cmd, fault, fault_clr,
        output gate_hi, gate_lo, dt_active, fault_latched
    );
endinterface

// File: rtl/deadtime_gate_driver.sv
// Three-phase dead-time inserter: one PWM command bit per phase in, a complementary
// high/low gate pair per phase out, with a guaranteed dead time between the switches of a leg.
// A latched fault or enable=0 forces every gate off and parks each leg in dead time.
// Optional feature macro: DEADTIME_PROG_EN (runtime dead time from dt_cfg instead of DEAD_CYCLES).
module deadtime_gate_driver #(
    parameter int unsigned DT_W        = 8,
    parameter int unsigned DEAD_CYCLES = 50
) (
    input logic                    clk,
    input logic                    reset_n,
    deadtime_gate_driver_if.slave  bus
);
    typedef enum logic [1:0] {StLoOn = 2'd0, StDt = 2'd1, StHiOn = 2'd2} phase_state_t;

    localparam logic [DT_W-1:0] DeadLast = DT_W'(DEAD_CYCLES - 1);

    phase_state_t    state_q [3];
    phase_state_t    state_d [3];
    logic [DT_W-1:0] cnt_q   [3];
    logic [DT_W-1:0] cnt_d   [3];
    logic [DT_W-1:0] dt_last [3];  // final count value of the current dead time (D-1)

    logic       fault_latched_q, fault_latched_d;
    logic       enable_q;
    logic       hold;
    logic [2:0] gate_hi_q, gate_hi_d;
    logic [2:0] gate_lo_q, gate_lo_d;
    logic [2:0] dt_active_q, dt_active_d;

    // Legs are parked while disabled, faulted (raw fault acts before the latch is visible),
    // and for one extra cycle after enable rises so release costs a full D+1 like a cmd edge.
    assign hold = ~bus.enable | ~enable_q | bus.fault | fault_latched_q;

    // Sticky fault: a simultaneous fault wins over fault_clr.
    assign fault_latched_d = bus.fault | (fault_latched_q & ~bus.fault_clr);

`ifdef DEADTIME_PROG_EN
    logic [DT_W-1:0] dt_len_q [3];
    logic [DT_W-1:0] dt_len_d [3];
    logic [DT_W-1:0] cfg_eff;

    assign cfg_eff = (bus.dt_cfg == '0) ? DT_W'(1) : bus.dt_cfg;

    // Shadow dead time tracks dt_cfg outside of a running dead time, frozen while counting.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            dt_len_d[i] = (hold || state_q[i] != StDt) ? cfg_eff : dt_len_q[i];
            dt_last[i]  = dt_len_q[i] - DT_W'(1);
        end
    end

    // Shadow dead-time registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) dt_len_q[i] <= DT_W'(DEAD_CYCLES);
        end else begin
            for (int i = 0; i < 3; i++) dt_len_q[i] <= dt_len_d[i];
        end
    end
`else
    // Fixed dead time for every leg.
    always_comb begin
        for (int i = 0; i < 3; i++) dt_last[i] = DeadLast;
    end
`endif

    // Per-phase next state and registered gate/dead-time outputs.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (hold) begin
                state_d[i] = StDt;
                cnt_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    StLoOn: begin
                        if (bus.pwm_cmd[i]) begin
                            state_d[i] = StDt;
                            cnt_d[i]   = '0;
                        end
                    end
                    StHiOn: begin
                        if (!bus.pwm_cmd[i]) begin
                            state_d[i] = StDt;
                            cnt_d[i]   = '0;
                        end
                    end
                    StDt: begin
                        // Dead time always completes; side is the cmd level at its last cycle.
                        if (cnt_q[i] >= dt_last[i]) begin
                            state_d[i] = bus.pwm_cmd[i] ? StHiOn : StLoOn;
                        end else begin
                            cnt_d[i] = cnt_q[i] + DT_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = StDt;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            gate_hi_d[i]   = (state_d[i] == StHiOn);
            gate_lo_d[i]   = (state_d[i] == StLoOn);
            dt_active_d[i] = (state_d[i] == StDt);
        end
    end

    // State, counters, fault latch and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= StDt;
                cnt_q[i]   <= '0;
            end
            fault_latched_q <= 1'b0;
            enable_q        <= 1'b1;
            gate_hi_q       <= 3'b000;
            gate_lo_q       <= 3'b000;
            dt_active_q     <= 3'b111;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            fault_latched_q <= fault_latched_d;
            enable_q        <= bus.enable;
            gate_hi_q       <= gate_hi_d;
            gate_lo_q       <= gate_lo_d;
            dt_active_q     <= dt_active_d;
        end
    end

    assign bus.gate_hi       = gate_hi_q;
    assign bus.gate_lo       = gate_lo_q;
    assign bus.dt_active     = dt_active_q;
    assign bus.fault_latched = fault_latched_q;
endmodule

// File: tb/tb_deadtime_gate_driver.sv
// Bench for deadtime_gate_driver: directed scenarios with literal expectations plus a
// randomized stress run, all checked every cycle against a timestamp-based leg model.
module tb_deadtime_gate_driver;
    localparam int unsigned DT_W = 8;
    localparam int          D    = 50;

    logic clk = 1'b0;
    logic reset_n;
    always #10 clk = ~clk;

`ifdef DEADTIME_PROG_EN
    deadtime_gate_driver_if #(.DT_W(DT_W)) bus ();
`else
    deadtime_gate_driver_if bus ();
`endif

    deadtime_gate_driver #(.DT_W(DT_W), .DEAD_CYCLES(D)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: each leg is either on one side (1=lo, 2=hi) or dead (0) since edge m_start,
    // for m_dlen edges; m_cyc counts clock edges since reset release.
    int   m_cyc;
    logic m_latched;
    logic m_en_prev;
    int   m_side  [3];
    int   m_start [3];
    int   m_dlen  [3];
    logic m_held;
    int   m_cfg;

    assign m_held = !bus.enable || !m_en_prev || bus.fault || m_latched;
`ifdef DEADTIME_PROG_EN
    assign m_cfg = (bus.dt_cfg == 0) ? 1 : int'(bus.dt_cfg);
`else
    assign m_cfg = D;
`endif

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cyc     <= 0;
            m_latched <= 1'b0;
            m_en_prev <= 1'b1;
            for (int i = 0; i < 3; i++) begin
                m_side[i]  <= 0;
                m_start[i] <= 0;
                m_dlen[i]  <= D;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_held || (m_side[i] == 1 && bus.pwm_cmd[i]) ||
                    (m_side[i] == 2 && !bus.pwm_cmd[i])) begin
                    m_side[i]  <= 0;
                    m_start[i] <= m_cyc + 1;
                    m_dlen[i]  <= m_cfg;
                end else if (m_side[i] == 0 && (m_cyc + 1 - m_start[i]) >= m_dlen[i]) begin
                    m_side[i] <= bus.pwm_cmd[i] ? 2 : 1;
                end
            end
            m_latched <= bus.fault || (m_latched && !bus.fault_clr);
            m_en_prev <= bus.enable;
            m_cyc     <= m_cyc + 1;
        end
    end

    logic [2:0] exp_hi, exp_lo, exp_dt;
    always_comb begin
        exp_hi = '0;
        exp_lo = '0;
        exp_dt = '0;
        for (int i = 0; i < 3; i++) begin
            exp_hi[i] = (m_side[i] == 2);
            exp_lo[i] = (m_side[i] == 1);
            exp_dt[i] = (m_side[i] == 0);
        end
    end

    // Per-cycle compare against the model, plus shoot-through and minimum off-gap checks.
    int   off_at [3];
    logic prev_on [3];
`ifdef DEADTIME_PROG_EN
    localparam int MinGap = 1;
`else
    localparam int MinGap = D;
`endif
    always @(negedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                off_at[i]  = 0;
                prev_on[i] = 1'b0;
            end
        end else begin
            n_tests++;
            if ({bus.gate_hi, bus.gate_lo, bus.dt_active, bus.fault_latched} !==
                {exp_hi, exp_lo, exp_dt, m_latched}) begin
                n_fail++;
                $display("FAIL model cyc=%0d: hi/lo/dt/lat got %b/%b/%b/%b expected %b/%b/%b/%b",
                         m_cyc, bus.gate_hi, bus.gate_lo, bus.dt_active, bus.fault_latched,
                         exp_hi, exp_lo, exp_dt, m_latched);
            end
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (bus.gate_hi[i] && bus.gate_lo[i]) begin
                    n_fail++;
                    $display("FAIL shoot_through phase %0d cyc=%0d: got hi=1 lo=1 required not both",
                             i, m_cyc);
                end
                if (prev_on[i] && !(bus.gate_hi[i] || bus.gate_lo[i])) off_at[i] = m_cyc;
                if (!prev_on[i] && (bus.gate_hi[i] || bus.gate_lo[i])) begin
                    n_tests++;
                    if (m_cyc - off_at[i] < MinGap) begin
                        n_fail++;
                        $display("FAIL off_gap phase %0d: got %0d cycles required >= %0d",
                                 i, m_cyc - off_at[i], MinGap);
                    end
                end
                prev_on[i] = bus.gate_hi[i] || bus.gate_lo[i];
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int         hold_cnt [3];
    logic [2:0] cmd_r;

    initial begin
        reset_n       = 1'b0;
        bus.enable    = 1'b1;
        bus.pwm_cmd   = 3'b000;
        bus.fault     = 1'b0;
        bus.fault_clr = 1'b0;
`ifdef DEADTIME_PROG_EN
        bus.dt_cfg    = 8'd50;
`endif
        step(3);
        check("reset_hi", {5'd0, bus.gate_hi}, 8'h00);
        check("reset_lo", {5'd0, bus.gate_lo}, 8'h00);
        check("reset_dt", {5'd0, bus.dt_active}, 8'h07);
        check("reset_latched", {7'd0, bus.fault_latched}, 8'h00);
        reset_n = 1'b1;

        // Start-up dead time.
        step(49);
        check("startup_lo_49", {5'd0, bus.gate_lo}, 8'h00);
        step(1);
        check("startup_lo_50", {5'd0, bus.gate_lo}, 8'h07);
        check("startup_hi_50", {5'd0, bus.gate_hi}, 8'h00);

        // Phase A low -> high.
        step(10);
        bus.pwm_cmd = 3'b001;
        step(1);
        check("a_lo_off", {5'd0, bus.gate_lo}, 8'h06);
        check("a_dt_on", {5'd0, bus.dt_active}, 8'h01);
        step(49);
        check("a_hi_t50", {5'd0, bus.gate_hi}, 8'h00);
        step(1);
        check("a_hi_t51", {5'd0, bus.gate_hi}, 8'h01);

        // Phase B high, then a 10-cycle low pulse is stretched into a full dead time.
        bus.pwm_cmd = 3'b011;
        step(51);
        check("b_hi_on", {5'd0, bus.gate_hi}, 8'h03);
        bus.pwm_cmd = 3'b001;
        step(10);
        bus.pwm_cmd = 3'b011;
        step(40);
        check("b_pulse_hi_off", {5'd0, bus.gate_hi}, 8'h01);
        check("b_pulse_lo", {5'd0, bus.gate_lo}, 8'h04);
        step(1);
        check("b_pulse_hi_back", {5'd0, bus.gate_hi}, 8'h03);

        // Fault latch.
        bus.fault = 1'b1;
        step(1);
        bus.fault = 1'b0;
        check("fault_gates", {2'd0, bus.gate_hi, bus.gate_lo}, 8'h00);
        check("fault_latched", {7'd0, bus.fault_latched}, 8'h01);
        bus.fault     = 1'b1;
        bus.fault_clr = 1'b1;
        step(1);
        check("fault_clr_blocked", {7'd0, bus.fault_latched}, 8'h01);
        bus.fault = 1'b0;
        step(1);
        bus.fault_clr = 1'b0;
        check("fault_cleared", {7'd0, bus.fault_latched}, 8'h00);
        step(49);
        check("fault_resume_49", {5'd0, bus.gate_hi}, 8'h00);
        step(1);
        check("fault_resume_hi", {5'd0, bus.gate_hi}, 8'h03);
        check("fault_resume_lo", {5'd0, bus.gate_lo}, 8'h04);

        // Enable drop and release.
        bus.enable = 1'b0;
        step(1);
        check("disable_gates", {2'd0, bus.gate_hi, bus.gate_lo}, 8'h00);
        check("disable_dt", {5'd0, bus.dt_active}, 8'h07);
        step(5);
        bus.enable = 1'b1;
        step(50);
        check("enable_resume_50", {5'd0, bus.gate_hi}, 8'h00);
        step(1);
        check("enable_resume_51", {5'd0, bus.gate_hi}, 8'h03);

        // Randomized stress; the per-cycle compare process does the checking.
        cmd_r = bus.pwm_cmd;
        for (int i = 0; i < 3; i++) hold_cnt[i] = $urandom_range(1, 120);
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold_cnt[i] == 0) begin
                    cmd_r[i]    = ~cmd_r[i];
                    hold_cnt[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8)
                                                              : $urandom_range(1, 120);
                end else begin
                    hold_cnt[i]--;
                end
            end
            bus.pwm_cmd   = cmd_r;
            bus.enable    = ($urandom_range(0, 299) != 0);
            bus.fault     = ($urandom_range(0, 399) == 0);
            bus.fault_clr = ($urandom_range(0, 29) == 0);
            step(1);
        end
        bus.enable    = 1'b1;
        bus.fault     = 1'b0;
        bus.fault_clr = 1'b1;
        step(1);
        bus.fault_clr = 1'b0;
        check("stress_latch_clear", {7'd0, bus.fault_latched}, 8'h00);
        bus.pwm_cmd = 3'b000;
        step(60);
        check("stress_settle_lo", {5'd0, bus.gate_lo}, 8'h07);

`ifdef DEADTIME_PROG_EN
        // Runtime dead time: mid-interval change applies only to the next interval.
        bus.dt_cfg = 8'd5;
        step(2);
        bus.pwm_cmd = 3'b001;
        step(1);
        check("prog_dt_start", {5'd0, bus.dt_active}, 8'h01);
        bus.dt_cfg = 8'd0;
        step(4);
        check("prog_dt5_hi_4", {5'd0, bus.gate_hi}, 8'h00);
        step(1);
        check("prog_dt5_hi_5", {5'd0, bus.gate_hi}, 8'h01);
        bus.pwm_cmd = 3'b000;
        step(1);
        check("prog_dt1_start", {5'd0, bus.dt_active}, 8'h07 & 8'h01);
        step(1);
        check("prog_dt1_lo", {5'd0, bus.gate_lo}, 8'h07);
`endif

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
